serial_sub_ctrl: RTL and testbench

// - Bit-serial N-bit subtractor controller: sequences one 1-bit subtractor cell over WIDTH cycles, LSB first.
// - Computes diff = a - b (mod 2^WIDTH) and borrow_out = (a < b), both unsigned.
// - Provides a start/ready/done handshake for an upstream requester.
// - Trades latency for area against a parallel ripple of half_sub pairs.

---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/full_sub_cell.sv | 30 +++
 rtl/half_sub.sv | 12 +
 rtl/serial_sub_ctrl.sv | 109 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encodings
// and the legal operand width range.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sub_state_e;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor cell: two half subtractors chained, borrows ORed.
module full_sub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d_ab;
   logic bout_ab;
   logic bout_bin;

   half_sub u_hs_ab (
      .a    (a),
      .b    (b),
      .d    (d_ab),
      .bout (bout_ab)
   );

   half_sub u_hs_bin (
      .a    (d_ab),
      .b    (bin),
      .d    (d),
      .bout (bout_bin)
   );

   assign bout = bout_ab | bout_bin;

endmodule

// File: rtl/half_sub.sv
// One-bit half subtractor: d = a - b, bout set when b exceeds a.
module half_sub (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: feeds one full_sub_cell LSB first over WIDTH
// cycles behind a start/ready/done handshake; diff and borrow_out are unsigned.
//
// Handshake: start is sampled only while ready=1 (IDLE); an accepted start
// captures a/b. done is a one-cycle pulse with diff/borrow_out already valid;
// results hold until a later operation completes. start outside IDLE is dropped.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic [1:0]       state_dbg
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   sub_state_e       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic [CNT_W-1:0] cnt;
   logic             bflop;
   logic             cell_d;
   logic             cell_bout;
   logic [WIDTH:0]   d_cat;
   logic [WIDTH-1:0] d_next;

   full_sub_cell u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (bflop),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // New difference bit enters at the MSB; written this way so WIDTH=1 needs no special case.
   assign d_cat     = {cell_d, d_sr};
   assign d_next    = d_cat[WIDTH:1];
   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         d_sr       <= '0;
         cnt        <= '0;
         bflop      <= 1'b0;
         ready      <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  d_sr  <= '0;
                  cnt   <= '0;
                  bflop <= 1'b0;
                  ready <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               d_sr  <= d_next;
               bflop <= cell_bout;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  diff       <= d_next;
                  borrow_out <= cell_bout;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;
   import serial_sub_pkg::*;

   logic       clk;
   logic       rst;

   logic       start8, ready8, busy8, done8, bo8;
   logic [7:0] a8, b8, diff8;
   logic [1:0] st8;

   logic       start1, ready1, busy1, done1, bo1;
   logic [0:0] a1, b1, diff1;
   logic [1:0] st1;

   int n_checks;
   int n_errors;

   serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
      .clk        (clk),
      .rst        (rst),
      .start      (start8),
      .a          (a8),
      .b          (b8),
      .ready      (ready8),
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
      .borrow_out (bo8),
      .state_dbg  (st8)
   );

   serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .start      (start1),
      .a          (a1),
      .b          (b1),
      .ready      (ready1),
      .busy       (busy1),
      .done       (done1),
      .diff       (diff1),
      .borrow_out (bo1),
      .state_dbg  (st1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One operation on either instance; inject>0 pulses a new start on that RUN cycle.
   task automatic run_op(input bit w1, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] ed, input logic eb, input int inject,
                         input string tag);
      int   cyc;
      logic dn;
      @(negedge clk);
      if (w1) begin
         check({tag, "_ready_pre"}, 32'(ready1), 32'd1);
         a1 = ta[0]; b1 = tb[0]; start1 = 1'b1;
      end else begin
         check({tag, "_ready_pre"}, 32'(ready8), 32'd1);
         a8 = ta; b8 = tb; start8 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0;
      start8 = 1'b0;
      cyc = 1;
      dn = w1 ? done1 : done8;
      while (!dn && cyc < 40) begin
         if (!w1 && cyc == inject) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01;
         end
         @(negedge clk);
         cyc++;
         if (start8) begin
            start8 = 1'b0;
            check({tag, "_ready_inrun"}, 32'(ready8), 32'd0);
         end
         dn = w1 ? done1 : done8;
      end
      check({tag, "_latency"}, 32'(cyc), w1 ? 32'd2 : 32'd9);
      if (w1) begin
         check({tag, "_diff"}, 32'(diff1), 32'(ed[0]));
         check({tag, "_borrow"}, 32'(bo1), 32'(eb));
      end else begin
         check({tag, "_diff"}, 32'(diff8), 32'(ed));
         check({tag, "_borrow"}, 32'(bo8), 32'(eb));
         check({tag, "_ready_done"}, 32'(ready8), 32'd0);
      end
      @(negedge clk);
      check({tag, "_done_width"}, w1 ? 32'(done1) : 32'(done8), 32'd0);
      check({tag, "_ready_post"}, w1 ? 32'(ready1) : 32'(ready8), 32'd1);
   endtask

   initial begin
      int gap;
      int seen;
      logic [7:0] ra, rb;
      n_checks = 0;
      n_errors = 0;
      start8 = 1'b0; a8 = '0; b8 = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready8), 32'd1);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_borrow", 32'(bo8), 32'd0);
      check("rst_state", 32'(st8), 32'(ST_IDLE));
      rst = 1'b0;

      // directed vectors
      run_op(1'b0, 8'd5,  8'd3,  8'h02, 1'b0, 0, "v5m3");
      run_op(1'b0, 8'd3,  8'd5,  8'hFE, 1'b1, 0, "v3m5");
      run_op(1'b0, 8'd0,  8'd1,  8'hFF, 1'b1, 0, "v0m1");
      run_op(1'b0, 8'hFF, 8'h00, 8'hFF, 1'b0, 0, "vffm0");
      run_op(1'b0, 8'hA5, 8'hA5, 8'h00, 1'b0, 0, "va5ma5");
      run_op(1'b0, 8'd5,  8'd3,  8'h02, 1'b0, 3, "ignore_start");
      run_op(1'b1, 8'd1,  8'd0,  8'd1,  1'b0, 0, "w1_1m0");
      run_op(1'b1, 8'd0,  8'd1,  8'd1,  1'b1, 0, "w1_0m1");
      run_op(1'b1, 8'd1,  8'd1,  8'd0,  1'b0, 0, "w1_1m1");

      // back-to-back with start held high
      @(negedge clk);
      a8 = 8'd5; b8 = 8'd3; start8 = 1'b1;
      gap = 0;
      while (!done8 && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      check("b2b_first_diff", 32'(diff8), 32'h02);
      a8 = 8'd3; b8 = 8'd5;
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!done8 && gap < 40);
      start8 = 1'b0;
      check("b2b_period", 32'(gap), 32'd10);
      check("b2b_second_diff", 32'(diff8), 32'hFE);
      check("b2b_second_borrow", 32'(bo8), 32'd1);
      repeat (2) @(negedge clk);

      // asynchronous reset in the middle of RUN
      a8 = 8'd5; b8 = 8'd3; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_ready", 32'(ready8), 32'd1);
      check("midrst_busy", 32'(busy8), 32'd0);
      check("midrst_diff", 32'(diff8), 32'd0);
      check("midrst_borrow", 32'(bo8), 32'd0);
      check("midrst_state", 32'(st8), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) seen++;
      end
      check("midrst_no_done", 32'(seen), 32'd0);

      // random operands against an unsigned model
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op(1'b0, ra, rb, ra - rb, (ra < rb), 0, "rnd8");
      end
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 1));
         rb = 8'($urandom_range(0, 1));
         run_op(1'b1, ra, rb, 8'(ra[0] ^ rb[0]), (ra[0] < rb[0]), 0, "rnd1");
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
